// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons, start/stop/clear FSM, 00.00..99.99 s BCD count.
// Optional lap freeze is built when STOPWATCH_LAP_EN is defined.

module stopwatch_debounce #(
  parameter logic [19:0] DEB_MAX = 20'd999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  logic        s1, s2, deb, deb_d;
  logic [19:0] deb_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      if (s2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        deb     <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end
  end

  assign press = deb & ~deb_d;
endmodule

module stopwatch_ctrl #(
  parameter logic [23:0] TICK_MAX = 24'd499_999,
  parameter logic [19:0] DEB_MAX  = 20'd999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
  output logic       lap_active,
`endif
  output logic [3:0] unit,
  output logic [3:0] ten,
  output logic [3:0] hun,
  output logic [3:0] tho,
  output logic       running,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;

  state_t      state, state_nxt;
  logic        ss_press, clr_press;
  logic        run_d, ovf_d;
  logic [23:0] presc;
  logic        tick;
  logic [15:0] cnt;
  logic        at_max;

  // Saturating 4-digit BCD increment; 9999 stays at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (d != 16'h9999) begin
      if (r[3:0] != 4'd9) begin
        r[3:0] = r[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (r[7:4] != 4'd9) begin
          r[7:4] = r[7:4] + 4'd1;
        end else begin
          r[7:4] = 4'd0;
          if (r[11:8] != 4'd9) begin
            r[11:8] = r[11:8] + 4'd1;
          end else begin
            r[11:8]  = 4'd0;
            r[15:12] = r[15:12] + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  stopwatch_debounce #(.DEB_MAX(DEB_MAX)) u_deb_ss (
    .clk(clk), .rst(rst), .raw(btn_start_stop), .press(ss_press)
  );
  stopwatch_debounce #(.DEB_MAX(DEB_MAX)) u_deb_clr (
    .clk(clk), .rst(rst), .raw(btn_clear), .press(clr_press)
  );

  assign tick   = (state == RUN) && (presc == TICK_MAX);
  assign at_max = (cnt == 16'h9999);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      running  <= run_d;
      overflow <= ovf_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ss_press) state_nxt = RUN;
      RUN: begin
        if (tick && at_max) state_nxt = FULL;
        else if (ss_press)  state_nxt = PAUSE;
      end
      PAUSE: begin
        if (clr_press)     state_nxt = IDLE;
        else if (ss_press) state_nxt = RUN;
      end
      FULL:  if (clr_press) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run_d = (state_nxt == RUN);
    ovf_d = (state_nxt == FULL);
  end

  // Prescaler keeps its phase across PAUSE so resumed timing stays exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? 24'd0 : presc + 24'd1;
    end else if (state != PAUSE) begin
      presc <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_nxt == IDLE) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= bcd_inc(cnt);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_press;
  logic [15:0] lap_cnt;

  stopwatch_debounce #(.DEB_MAX(DEB_MAX)) u_deb_lap (
    .clk(clk), .rst(rst), .raw(btn_lap), .press(lap_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_active <= 1'b0;
      lap_cnt    <= '0;
    end else if (state_nxt == IDLE || state_nxt == FULL) begin
      lap_active <= 1'b0;
    end else if (lap_press) begin
      if (lap_active) begin
        lap_active <= 1'b0;
      end else if (state == RUN) begin
        lap_cnt    <= cnt;
        lap_active <= 1'b1;
      end
    end
  end

  assign {tho, hun, ten, unit} = lap_active ? lap_cnt : cnt;
`else
  assign {tho, hun, ten, unit} = cnt;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_MAX=4, DEB_MAX=3 (tick every 5 clk).
// A clean press changes state on the 7th posedge after the button is raised.

module tb_stopwatch_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap = 1'b0;
  logic       lap_active;
`endif
  logic [3:0] unit, ten, hun, tho;
  logic       running, overflow;
  logic [15:0] disp;
  int total = 0;
  int bad = 0;

  assign disp = {tho, hun, ten, unit};

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_MAX(24'd4), .DEB_MAX(20'd3)) dut (
    .clk(clk),
    .rst(rst),
    .btn_start_stop(btn_start_stop),
    .btn_clear(btn_clear),
`ifdef STOPWATCH_LAP_EN
    .btn_lap(btn_lap),
    .lap_active(lap_active),
`endif
    .unit(unit),
    .ten(ten),
    .hun(hun),
    .tho(tho),
    .running(running),
    .overflow(overflow)
  );

  // Called at a negedge; returns at the negedge right after the state-change edge.
  task automatic press(input bit ss, input bit cl, input bit lp);
    btn_start_stop = ss;
    btn_clear      = cl;
`ifdef STOPWATCH_LAP_EN
    btn_lap        = lp;
`endif
    repeat (7) @(negedge clk);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    btn_lap        = 1'b0;
`else
    if (lp) $display("lap stimulus skipped");
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h want=%h", disp, 16'h0000); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_run_1000();
    do_reset();
    press(1, 0, 0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running got=%b want=1", running); end
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL start_digits got=%h want=%h", disp, 16'h0000); end
    repeat (4999) @(negedge clk);
    total++; if (disp !== 16'h0999) begin bad++; $display("FAIL run999 got=%h want=%h", disp, 16'h0999); end
    repeat (3) @(negedge clk);
    total++; if (disp !== 16'h1000) begin bad++; $display("FAIL run1000 got=%h want=%h", disp, 16'h1000); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run1000_running got=%b want=1", running); end
    do_reset();
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL midrun_reset got=%h want=%h", disp, 16'h0000); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL midrun_reset_running got=%b want=0", running); end
  endtask

  task automatic test_pause_clear();
    do_reset();
    press(1, 0, 0);
    repeat (20) @(negedge clk);
    press(0, 1, 0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL clear_in_run_running got=%b want=1", running); end
    total++; if (disp !== 16'h0005) begin bad++; $display("FAIL clear_in_run_digits got=%h want=%h", disp, 16'h0005); end
    repeat (153) @(negedge clk);
    press(1, 0, 0);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b want=0", running); end
    repeat (200) @(negedge clk);
    total++; if (disp !== 16'h0037) begin bad++; $display("FAIL pause_hold got=%h want=%h", disp, 16'h0037); end
    press(1, 0, 0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running got=%b want=1", running); end
    repeat (2) @(negedge clk);
    total++; if (disp !== 16'h0037) begin bad++; $display("FAIL resume_phase_early got=%h want=%h", disp, 16'h0037); end
    @(negedge clk);
    total++; if (disp !== 16'h0038) begin bad++; $display("FAIL resume_phase_tick got=%h want=%h", disp, 16'h0038); end
    repeat (10) @(negedge clk);
    press(1, 0, 0);
    total++; if (disp !== 16'h0041) begin bad++; $display("FAIL repause_digits got=%h want=%h", disp, 16'h0041); end
    press(0, 1, 0);
    total++; if (disp !== 16'h0000) begin bad++; $display("FAIL clear_in_pause got=%h want=%h", disp, 16'h0000); end
    total++; if (running !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL clear_in_pause_flags got=%b%b want=00", running, overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    press(1, 0, 0);
    repeat (49997) @(negedge clk);
    total++; if (disp !== 16'h9999) begin bad++; $display("FAIL at9999 got=%h want=%h", disp, 16'h9999); end
    total++; if (overflow !== 1'b0 || running !== 1'b1) begin bad++; $display("FAIL at9999_flags ovf/run got=%b%b want=01", overflow, running); end
    repeat (5) @(negedge clk);
    total++; if (disp !== 16'h9999) begin bad++; $display("FAIL full_digits got=%h want=%h", disp, 16'h9999); end
    total++; if (overflow !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL full_flags ovf/run got=%b%b want=10", overflow, running); end
    press(1, 0, 0);
    total++; if (overflow !== 1'b1 || disp !== 16'h9999) begin bad++; $display("FAIL full_ignores_start ovf=%b digits=%h want 1 9999", overflow, disp); end
    press(0, 1, 0);
    total++; if (disp !== 16'h0000 || overflow !== 1'b0) begin bad++; $display("FAIL full_clear digits=%h ovf=%b want 0000 0", disp, overflow); end
  endtask

  task automatic test_debounce_and_priority();
    do_reset();
    btn_start_stop = 1'b1;
    repeat (3) @(negedge clk);
    btn_start_stop = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL short_pulse running got=%b want=0", running); end
    btn_start_stop = 1'b1;
    repeat (4) @(negedge clk);
    btn_start_stop = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL min_pulse running got=%b want=1", running); end
    press(1, 0, 0);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL prio_pause running got=%b want=0", running); end
    repeat (10) @(negedge clk);
    press(1, 1, 0);
    total++; if (running !== 1'b0 || disp !== 16'h0000) begin bad++; $display("FAIL clear_wins run=%b digits=%h want 0 0000", running, disp); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    do_reset();
    press(1, 0, 0);
    repeat (610) @(negedge clk);
    press(0, 0, 1);
    total++; if (disp !== 16'h0123 || lap_active !== 1'b1) begin bad++; $display("FAIL lap_capture digits=%h lap=%b want 0123 1", disp, lap_active); end
    repeat (245) @(negedge clk);
    total++; if (disp !== 16'h0123 || lap_active !== 1'b1) begin bad++; $display("FAIL lap_hold digits=%h lap=%b want 0123 1", disp, lap_active); end
    press(0, 0, 1);
    total++; if (disp !== 16'h0173 || lap_active !== 1'b0) begin bad++; $display("FAIL lap_release digits=%h lap=%b want 0173 0", disp, lap_active); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_run_1000();
    test_pause_clear();
    test_overflow();
    test_debounce_and_priority();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
